// File: rtl/team_06_audio_pkg.sv
// Shared audio-path types and constants for the volume shifter and PWM output stage.
package team_06_audio_pkg;

    localparam int DEFAULT_PWM_BITS = 8;

    typedef logic [DEFAULT_PWM_BITS-1:0] sample_t;

    localparam sample_t SILENCE = '0;

endpackage

// File: rtl/team_06_pwm_timebase.sv
// PWM timebase: counts clocks within a frame and frames within a sample period.
// Strobes are combinational from the counters; the counters are held at zero while disabled.
module team_06_pwm_timebase
    import team_06_audio_pkg::*;
#(
    parameter int PWM_BITS          = DEFAULT_PWM_BITS,
    parameter int FRAMES_PER_SAMPLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                frame_wrap,
    output logic                boundary
);

    localparam logic [PWM_BITS-1:0] CNT_MAX    = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE    = 1;
    localparam logic [3:0]          FRAME_LAST = 4'(FRAMES_PER_SAMPLE - 1);

    logic [3:0] frame_cnt;

    assign frame_wrap = enable & (pwm_cnt == CNT_MAX);
    assign boundary   = frame_wrap & (frame_cnt == FRAME_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            frame_cnt <= '0;
        end else if (!enable) begin
            pwm_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + CNT_ONE;
            if (frame_wrap) begin
                frame_cnt <= (frame_cnt == FRAME_LAST) ? 4'd0 : frame_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/team_06_pwm_audio_out.sv
// PWM audio output: one-entry sample buffer replayed for FRAMES_PER_SAMPLE PWM frames per sample.
// pwm_out lags pwm_cnt by one clock; sample_ready is low while the buffer holds an unplayed sample.
module team_06_pwm_audio_out
    import team_06_audio_pkg::*;
#(
    parameter int PWM_BITS          = DEFAULT_PWM_BITS,
    parameter int FRAMES_PER_SAMPLE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] sample_in,
    input  logic                sample_valid,
    output logic                sample_ready,
    output logic                sample_req,
    output logic                pwm_out,
    output logic                underrun,
    input  logic                underrun_clr
);

    localparam logic [PWM_BITS-1:0] IDLE = PWM_BITS'(SILENCE);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] next_sample;
    logic [PWM_BITS-1:0] active_sample;
    logic                next_full;
    logic                next_full_nxt;
    logic                ready_q;
    logic                frame_wrap;
    logic                boundary;
    logic                transfer;

    team_06_pwm_timebase #(
        .PWM_BITS          (PWM_BITS),
        .FRAMES_PER_SAMPLE (FRAMES_PER_SAMPLE)
    ) u_timebase (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pwm_cnt    (pwm_cnt),
        .frame_wrap (frame_wrap),
        .boundary   (boundary)
    );

    // Ready is registered so it is low throughout reset regardless of enable.
    assign sample_ready = ready_q;
    assign sample_req   = boundary;
    assign transfer     = sample_valid & ready_q;

    always_comb begin
        next_full_nxt = next_full;
        if (!enable) begin
            next_full_nxt = 1'b0;
        end else begin
            if (boundary && next_full) begin
                next_full_nxt = 1'b0;
            end
            if (transfer) begin
                next_full_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_full     <= 1'b0;
            next_sample   <= IDLE;
            active_sample <= IDLE;
            ready_q       <= 1'b0;
            pwm_out       <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            next_full <= next_full_nxt;
            ready_q   <= enable & ~next_full_nxt;

            if (!enable) begin
                active_sample <= IDLE;
            end else if (boundary && next_full) begin
                active_sample <= next_sample;
            end

            if (enable && transfer) begin
                next_sample <= sample_in;
            end

            pwm_out <= enable & (pwm_cnt < active_sample);

            // A fresh underrun beats a simultaneous clear.
            if (boundary && !next_full) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
        end
    end

    boundary_on_frame_wrap: assert property (@(posedge clk) disable iff (rst) boundary |-> frame_wrap);

endmodule

// File: tb/tb_team_06_pwm_audio_out.sv
// Directed bench for team_06_pwm_audio_out with two PWM frames per sample (512-clock sample period).
module tb_team_06_pwm_audio_out;

    localparam int FPS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [7:0] sample_in;
    logic       sample_valid;
    logic       sample_ready;
    logic       sample_req;
    logic       pwm_out;
    logic       underrun;
    logic       underrun_clr;

    int total = 0;
    int bad   = 0;

    team_06_pwm_audio_out #(
        .PWM_BITS          (8),
        .FRAMES_PER_SAMPLE (FPS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_req   (sample_req),
        .pwm_out      (pwm_out),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Returns the number of clocks until sample_req is seen, or -1 on timeout.
    task automatic wait_req(output int n);
        n = -1;
        for (int i = 1; i <= 2000; i++) begin
            step();
            if (sample_req === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic load(input logic [7:0] v, output int ok);
        ok           = 0;
        sample_in    = v;
        sample_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if (sample_ready === 1'b1) begin
                step();
                ok = 1;
                break;
            end
            step();
        end
        sample_valid = 1'b0;
    endtask

    // Starting at the cycle where pwm_cnt is 0, covers one frame of output.
    task automatic measure256(output int hi, output int runs);
        logic prev;
        hi   = 0;
        runs = 0;
        prev = 1'b0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (pwm_out === 1'b1) begin
                hi++;
                if (!prev) runs++;
            end
            prev = (pwm_out === 1'b1);
        end
    endtask

    task automatic restart();
        enable       = 1'b0;
        sample_valid = 1'b0;
        step();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        enable       = 1'b1;
        step();
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        enable       = 1'b1;
        sample_valid = 1'b0;
        sample_in    = 8'h00;
        underrun_clr = 1'b0;
        @(negedge clk);
        total++;
        if ({pwm_out, sample_ready, sample_req, underrun} !== 4'b0000)
            begin bad++; $display("FAIL reset_outputs got=%b want=0000", {pwm_out, sample_ready, sample_req, underrun}); end
        step();
        rst = 1'b0;
        step();
        total++;
        if (sample_ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after got=%b want=1", sample_ready); end
        total++;
        if (pwm_out !== 1'b0) begin bad++; $display("FAIL reset_pwm_after got=%b want=0", pwm_out); end
    endtask

    task automatic test_basic();
        int ok, n, hi, runs;
        restart();
        load(8'h40, ok);
        total++;
        if (ok != 1) begin bad++; $display("FAIL basic_load got=%0d want=1", ok); end
        wait_req(n);
        // enable rose two cycles ago; the boundary is counted cycle 511
        total++;
        if (n != 509) begin bad++; $display("FAIL basic_first_boundary got=%0d want=509", n); end
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL basic_no_underrun got=%b want=0", underrun); end
        step();
        measure256(hi, runs);
        total++;
        if (hi != 64 || runs != 1) begin bad++; $display("FAIL basic_duty got=%0d/%0d want=64/1", hi, runs); end
        wait_req(n);
        total++;
        if (n != 255) begin bad++; $display("FAIL basic_req_phase got=%0d want=255", n); end
        wait_req(n);
        total++;
        if (n != 512) begin bad++; $display("FAIL basic_req_period got=%0d want=512", n); end
        step();
        total++;
        if (sample_req !== 1'b0) begin bad++; $display("FAIL basic_req_width got=%b want=0", sample_req); end
    endtask

    task automatic test_extremes();
        int ok, n, hi, runs;
        restart();
        load(8'hFF, ok);
        wait_req(n);
        step();
        measure256(hi, runs);
        total++;
        if (hi != 255 || runs != 1) begin bad++; $display("FAIL full_scale_duty got=%0d/%0d want=255/1", hi, runs); end
        load(8'h00, ok);
        wait_req(n);
        total++;
        if (n <= 0) begin bad++; $display("FAIL silence_boundary got=%0d want=>0", n); end
        hi = 0;
        for (int i = 0; i < 512; i++) begin
            step();
            if (pwm_out === 1'b1) hi++;
        end
        total++;
        if (hi != 0) begin bad++; $display("FAIL silence_duty got=%0d want=0", hi); end
    endtask

    task automatic test_back_to_back();
        int n, hi, runs;
        restart();
        sample_valid = 1'b1;
        sample_in    = 8'h10;
        total++;
        if (sample_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_initial got=%b want=1", sample_ready); end
        step();
        sample_in = 8'h20;
        total++;
        if (sample_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_drop got=%b want=0", sample_ready); end
        wait_req(n);
        step();
        total++;
        if (sample_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_return1 got=%b want=1", sample_ready); end
        measure256(hi, runs);
        total++;
        if (hi != 16) begin bad++; $display("FAIL b2b_duty_10 got=%0d want=16", hi); end
        total++;
        if (sample_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready_full got=%b want=0", sample_ready); end
        sample_in = 8'h30;
        wait_req(n);
        step();
        total++;
        if (sample_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_return2 got=%b want=1", sample_ready); end
        measure256(hi, runs);
        sample_valid = 1'b0;
        total++;
        if (hi != 32) begin bad++; $display("FAIL b2b_duty_20 got=%0d want=32", hi); end
        wait_req(n);
        step();
        measure256(hi, runs);
        total++;
        if (hi != 48) begin bad++; $display("FAIL b2b_duty_30 got=%0d want=48", hi); end
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL b2b_no_underrun got=%b want=0", underrun); end
    endtask

    task automatic test_underrun();
        int ok, n, hi, runs;
        restart();
        load(8'h80, ok);
        wait_req(n);
        step();
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL ur_after_load got=%b want=0", underrun); end
        wait_req(n);
        step();
        total++;
        if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set got=%b want=1", underrun); end
        measure256(hi, runs);
        total++;
        if (hi != 128) begin bad++; $display("FAIL ur_repeat_duty got=%0d want=128", hi); end
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL ur_clear got=%b want=0", underrun); end
        wait_req(n);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        total++;
        if (underrun !== 1'b1) begin bad++; $display("FAIL ur_set_beats_clear got=%b want=1", underrun); end
    endtask

    task automatic test_enable_drop();
        int ok, n, hi, runs;
        restart();
        load(8'h80, ok);
        wait_req(n);
        load(8'h40, ok);
        for (int i = 0; i < 8; i++) step();
        total++;
        if ({pwm_out, sample_ready} !== 2'b10) begin bad++; $display("FAIL en_mid_frame got=%b want=10", {pwm_out, sample_ready}); end
        enable = 1'b0;
        step();
        total++;
        if ({pwm_out, sample_ready, sample_req} !== 3'b000) begin bad++; $display("FAIL en_drop got=%b want=000", {pwm_out, sample_ready, sample_req}); end
        for (int i = 0; i < 20; i++) step();
        enable = 1'b1;
        wait_req(n);
        total++;
        if (n != 511) begin bad++; $display("FAIL en_first_boundary got=%0d want=511", n); end
        step();
        total++;
        if (underrun !== 1'b1) begin bad++; $display("FAIL en_flush_underrun got=%b want=1", underrun); end
        measure256(hi, runs);
        total++;
        if (hi != 0) begin bad++; $display("FAIL en_flushed_duty got=%0d want=0", hi); end
    endtask

    task automatic test_async_reset();
        int ok, n;
        load(8'hFF, ok);
        wait_req(n);
        for (int i = 0; i < 4; i++) step();
        total++;
        if ({pwm_out, sample_ready, underrun} !== 3'b111) begin bad++; $display("FAIL ar_before got=%b want=111", {pwm_out, sample_ready, underrun}); end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({pwm_out, sample_ready, sample_req, underrun} !== 4'b0000)
            begin bad++; $display("FAIL ar_immediate got=%b want=0000", {pwm_out, sample_ready, sample_req, underrun}); end
        @(negedge clk);
        rst = 1'b0;
        step();
        total++;
        if ({pwm_out, sample_ready} !== 2'b01) begin bad++; $display("FAIL ar_release got=%b want=01", {pwm_out, sample_ready}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_back_to_back();
        test_underrun();
        test_enable_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
